// File: rtl/bp_mem_delay_buffer.sv
// bp_mem_delay_buffer: in-order FIFO that holds each entry for a fixed
// latency plus optional LFSR jitter before presenting it downstream.
//
// Ports:
//   clk_i, reset_i     clock, synchronous active-high reset
//   data_i, v_i        upstream payload / valid
//   ready_o            space available (transfer on v_i & ready_o)
//   data_o, v_o        head payload / head present and delay expired
//   ready_i            downstream accept (transfer on v_o & ready_i)
//   count_o            current occupancy
module bp_mem_delay_buffer #(
  parameter int          width_p        = 1,
  parameter int          els_p          = 4,
  parameter int          latency_p      = 8,
  parameter int          jitter_width_p = 0,
  parameter logic [15:0] seed_p         = 16'hACE1
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [width_p-1:0]       data_i,
  input  logic                     v_i,
  output logic                     ready_o,
  output logic [width_p-1:0]       data_o,
  output logic                     v_o,
  input  logic                     ready_i,
  output logic [$clog2(els_p):0]   count_o
);

  localparam int aw = $clog2(els_p);
  localparam int cw = $clog2(latency_p + (1 << jitter_width_p));
  localparam logic [cw-1:0] lat_m1 = cw'(latency_p - 1);

  // MSB of each pointer is the wrap bit
  logic [aw:0]          wr_ptr;
  logic [aw:0]          rd_ptr;
  logic [aw-1:0]        wr_idx;
  logic [aw-1:0]        rd_idx;
  logic [width_p-1:0]   mem [els_p];
  logic [cw-1:0]        ctr [els_p];
  logic [15:0]          lfsr;
  logic [15:0]          lfsr_nxt;
  logic [cw-1:0]        jitter;
  logic [cw-1:0]        load;
  logic                 full;
  logic                 empty;
  logic                 enq;
  logic                 deq;

  assign wr_idx = wr_ptr[aw-1:0];
  assign rd_idx = rd_ptr[aw-1:0];

  assign full  = (wr_idx == rd_idx) && (wr_ptr[aw] != rd_ptr[aw]);
  assign empty = (wr_ptr == rd_ptr);

  assign ready_o = ~full & ~reset_i;
  assign v_o     = ~empty & (ctr[rd_idx] == '0);
  assign data_o  = mem[rd_idx];
  assign count_o = wr_ptr - rd_ptr;

  assign enq = v_i & ready_o;
  assign deq = v_o & ready_i;

  // x^16+x^14+x^13+x^11+1, right-shifting Fibonacci form
  assign lfsr_nxt = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};

  if (jitter_width_p > 0) begin : g_jit
    assign jitter = cw'(lfsr[jitter_width_p-1:0]);
  end else begin : g_nojit
    assign jitter = '0;
  end

  assign load = lat_m1 + jitter;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      lfsr   <= seed_p;
    end else begin
      if (enq) begin
        wr_ptr <= wr_ptr + 1'b1;
        lfsr   <= lfsr_nxt;
      end
      if (deq) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Every counter runs independently, so a blocked head never
  // delays the expiry of the entries behind it. Free slots just
  // settle at zero and are reloaded on enqueue.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < els_p; i++) begin
      if (reset_i) begin
        ctr[i] <= '0;
      end else if (enq && (wr_idx == aw'(i))) begin
        ctr[i] <= load;
      end else if (ctr[i] != '0) begin
        ctr[i] <= ctr[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) begin
      mem[wr_idx] <= data_i;
    end
  end

endmodule

// File: tb/tb_bp_mem_delay_buffer.sv
// tb_bp_mem_delay_buffer: randomized scoreboard bench for the
// delay buffer, with a queue-of-release-times reference model.
module tb_bp_mem_delay_buffer;

  localparam int W   = 8;
  localparam int ELS = 4;
  localparam int LAT = 6;
  localparam int JW  = 2;
  localparam logic [15:0] SEED = 16'hACE1;

  logic                   clk = 1'b0;
  logic                   reset_i = 1'b1;
  logic [W-1:0]           data_i = '0;
  logic                   v_i = 1'b0;
  logic                   ready_o;
  logic [W-1:0]           data_o;
  logic                   v_o;
  logic                   ready_i = 1'b0;
  logic [$clog2(ELS):0]   count_o;

  bp_mem_delay_buffer #(
    .width_p(W),
    .els_p(ELS),
    .latency_p(LAT),
    .jitter_width_p(JW),
    .seed_p(SEED)
  ) dut (
    .clk_i(clk),
    .reset_i(reset_i),
    .data_i(data_i),
    .v_i(v_i),
    .ready_o(ready_o),
    .data_o(data_o),
    .v_o(v_o),
    .ready_i(ready_i),
    .count_o(count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] d;
    int           rel;
  } item_t;

  item_t       q[$];
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;
  logic [15:0] m_lfsr = SEED;
  bit          enq_now = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, got, exp);
    end
  endtask

  // One cycle of stimulus; an accepted command is scored immediately
  // with the cycle at which it may first leave the buffer.
  task automatic step(input bit v, input logic [W-1:0] d,
                      input bit r, input bit rst);
    @(posedge clk);
    #1;
    if (reset_i) begin
      q.delete();
      m_lfsr = SEED;
    end
    reset_i = rst;
    v_i     = v;
    data_i  = d;
    ready_i = r;
    #1;
    enq_now = v_i && ready_o;
    if (enq_now) begin
      q.push_back('{d, cyc + LAT + int'(m_lfsr[JW-1:0])});
      m_lfsr = lfsr_step(m_lfsr);
    end
  endtask

  // Monitor: compares the DUT against the model every cycle and
  // retires the head on each downstream handshake.
  always @(negedge clk) begin
    int    n;
    bit    exp_v;
    item_t it;
    if (cyc >= 1) begin
      n = q.size() - int'(enq_now);
      exp_v = (n > 0) && (cyc >= q[0].rel);
      chk("v_o", 32'(v_o), 32'(exp_v));
      chk("ready_o", 32'(ready_o), 32'(!reset_i && n < ELS));
      chk("count_o", 32'(count_o), 32'(n));
      if (v_o && n > 0) chk("data_o", 32'(data_o), 32'(q[0].d));
      if (v_o && ready_i && !reset_i) begin
        if (n > 0) begin
          it = q.pop_front();
        end else begin
          chk("spurious_deq", 32'(1), 32'(0));
        end
      end
    end
  end

  initial begin
    int b;
    repeat (3) step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0);

    // single command latency
    step(1'b1, 8'h5A, 1'b1, 1'b0);
    repeat (15) step(1'b0, '0, 1'b1, 1'b0);

    // streaming burst
    for (int i = 0; i < 4; i++) step(1'b1, 8'(i + 1), 1'b1, 1'b0);
    repeat (15) step(1'b0, '0, 1'b1, 1'b0);

    // fill, then hold backpressure
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    step(1'b1, 8'hFF, 1'b0, 1'b0);
    repeat (20) step(1'b0, '0, 1'b0, 1'b0);
    repeat (15) step(1'b0, '0, 1'b1, 1'b0);

    // random traffic
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom),
           $urandom_range(0, 3) != 0, 1'b0);
    repeat (15) step(1'b0, '0, 1'b1, 1'b0);

    // reset with entries in flight, then a fresh command
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 8'h5A, 1'b1, 1'b0);
    repeat (15) step(1'b0, '0, 1'b1, 1'b0);

    // random traffic with occasional resets
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom),
           $urandom_range(0, 2) != 0, $urandom_range(0, 99) == 0);

    b = 0;
    while (q.size() > 0 && b < 100) begin
      step(1'b0, '0, 1'b1, 1'b0);
      b++;
    end
    @(negedge clk);
    #1;
    chk("drain_left", 32'(q.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
